// File: rtl/tri_bus_arb_pkg.sv
// Shared types and helpers for the tri-state bus arbiter.
// FSM encoding, default timing constants, one-hot helper.
package tri_bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } arb_state_e;

  localparam int MAX_REQ        = 16;
  localparam int DEF_MAX_HOLD   = 16;
  localparam int DEF_TURNAROUND = 1;

  function automatic logic [MAX_REQ-1:0] onehot(
    input logic [3:0] idx
  );
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Round-robin winner select: first set req bit at or above
// ptr, wrapping, via a double-width masked priority encoder.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  logic [2*N_REQ-1:0] dbl;
  logic [2*N_REQ-1:0] mask;
  logic [2*N_REQ-1:0] hit;

  always_comb begin
    dbl  = {req, req};
    mask = {(2*N_REQ){1'b1}} << ptr;
    hit  = dbl & mask;
    any  = |req;
    idx  = '0;
    // Descending scan leaves the lowest hit; upper copy covers wrap.
    for (int i = 2*N_REQ-1; i >= 0; i--) begin
      if (hit[i]) begin
        if (i >= N_REQ) idx = ID_W'(i - N_REQ);
        else            idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Owner arbitration for a shared tri-state/wired net with
// forced release, turnaround gap and keeper control.
module tri_bus_arbiter
  import tri_bus_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MAX_HOLD   = DEF_MAX_HOLD,
  parameter int TURNAROUND = DEF_TURNAROUND,
  parameter int ID_W       = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] last,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] drive_en,
  output logic             keeper_en,
  output logic             bus_busy,
  output logic [ID_W-1:0]  owner_id,
  output logic             timeout
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURNAROUND + 1);

  arb_state_e       state, nxt_state;
  logic [ID_W-1:0]  ptr, nxt_ptr;
  logic [HW-1:0]    hold, nxt_hold;
  logic [TW-1:0]    turn_cnt, nxt_turn;
  logic [N_REQ-1:0] grant_q, nxt_grant;
  logic [ID_W-1:0]  owner_q, nxt_owner;
  logic             timeout_q, nxt_timeout;

  logic            pick_any;
  logic [ID_W-1:0] pick_idx;
  logic            rel_last, rel_drop, at_max;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign rel_last = last[owner_q];
  assign rel_drop = ~req[owner_q];
  assign at_max   = (hold == HW'(MAX_HOLD));

  always_comb begin
    nxt_state   = state;
    nxt_ptr     = ptr;
    nxt_hold    = hold;
    nxt_turn    = turn_cnt;
    nxt_grant   = grant_q;
    nxt_owner   = owner_q;
    nxt_timeout = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (pick_any) begin
          nxt_state = ST_GRANT;
          nxt_grant = N_REQ'(onehot(4'(pick_idx)));
          nxt_owner = pick_idx;
          nxt_hold  = HW'(1);
        end
      end
      ST_GRANT: begin
        if (rel_last || rel_drop || at_max) begin
          nxt_state   = ST_TURN;
          nxt_grant   = '0;
          nxt_turn    = TW'(1);
          nxt_timeout = at_max & ~rel_last & ~rel_drop;
          if (owner_q == ID_W'(N_REQ - 1)) nxt_ptr = '0;
          else                             nxt_ptr = owner_q + 1'b1;
        end else begin
          nxt_hold = hold + HW'(1);
        end
      end
      ST_TURN: begin
        if (turn_cnt == TW'(TURNAROUND)) begin
          if (pick_any) begin
            nxt_state = ST_GRANT;
            nxt_grant = N_REQ'(onehot(4'(pick_idx)));
            nxt_owner = pick_idx;
            nxt_hold  = HW'(1);
          end else begin
            nxt_state = ST_IDLE;
          end
        end else begin
          nxt_turn = turn_cnt + TW'(1);
        end
      end
      default: nxt_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      hold      <= '0;
      turn_cnt  <= '0;
      grant_q   <= '0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state     <= nxt_state;
      ptr       <= nxt_ptr;
      hold      <= nxt_hold;
      turn_cnt  <= nxt_turn;
      grant_q   <= nxt_grant;
      owner_q   <= nxt_owner;
      timeout_q <= nxt_timeout;
    end
  end

  // Enables come straight from the async-reset register.
  assign grant     = grant_q;
  assign drive_en  = grant_q;
  assign keeper_en = ~|grant_q;
  assign bus_busy  = (state == ST_GRANT);
  assign owner_id  = owner_q;
  assign timeout   = timeout_q;

endmodule
